// File: rtl/audio_pkg.sv
// Shared audio types and helpers for the PCM monitor path.
//   PCM_W / MAG_W : sample and magnitude widths
//   pcm_t / mag_t : signed PCM sample, unsigned magnitude
//   pcm_abs()     : saturating absolute value (-32768 maps to 32767)
package audio_pkg;

    localparam int PCM_W = 16;
    localparam int MAG_W = 15;

    typedef logic signed [PCM_W-1:0] pcm_t;
    typedef logic        [MAG_W-1:0] mag_t;

    function automatic mag_t pcm_abs(input pcm_t x);
        logic [PCM_W-1:0] neg;
        neg = -x;
        if (x == pcm_t'({1'b1, {(PCM_W-1){1'b0}}}))
            return '1;
        else if (x[PCM_W-1])
            return neg[MAG_W-1:0];
        else
            return x[MAG_W-1:0];
    endfunction

endpackage

// File: rtl/pcm_level_meter_if.sv
// PCM sample stream: one-cycle strobe per sample, no backpressure.
//   tdata_pcm  : signed PCM sample
//   tvalid_pcm : sample strobe
//   master drives the stream, slave consumes it.
interface pcm_level_meter_if;
    import audio_pkg::*;

    pcm_t tdata_pcm;
    logic tvalid_pcm;

    modport master (output tdata_pcm, output tvalid_pcm);
    modport slave  (input  tdata_pcm, input  tvalid_pcm);

endinterface

// File: rtl/pcm_log2_bin.sv
// Combinational MSB priority encoder for the bar graph.
//   x   : magnitude
//   bin : 0 when x==0, otherwise index of the MSB plus one (0..15)
module pcm_log2_bin
    import audio_pkg::*;
(
    input  mag_t       x,
    output logic [3:0] bin
);

    always_comb begin
        bin = '0;
        for (int i = 0; i < MAG_W; i++) begin
            if (x[i]) bin = 4'(i + 1);
        end
    end

endmodule

// File: rtl/pcm_level_meter.sv
// PCM level meter: fast-attack/slow-decay envelope, held peak, log2 bar
// graph with peak dot and a clip indicator. Pure monitor, no backpressure.
//   clk      : system clock
//   arstn    : asynchronous active-low reset
//   pcm      : sample stream (slave side)
//   level    : current envelope magnitude (valid two cycles after a sample)
//   led      : bar graph plus peak dot (valid three cycles after a sample)
//   clip_led : lit while the clip hold counter is running
module pcm_level_meter
    import audio_pkg::*;
#(
    parameter int LEDS         = 16,
    parameter int DECAY_EVERY  = 64,
    parameter int DECAY_SHIFT  = 3,
    parameter int HOLD_SAMPLES = 4096,
    parameter int CLIP_THRESH  = 32000,
    parameter int CLIP_HOLD    = 8192
) (
    input  logic                 clk,
    input  logic                 arstn,
    pcm_level_meter_if.slave     pcm,
    output logic [MAG_W-1:0]     level,
    output logic [LEDS-1:0]      led,
    output logic                 clip_led
);

    localparam int DW = $clog2(DECAY_EVERY);
    localparam int HW = $clog2(HOLD_SAMPLES);
    localparam int CW = $clog2(CLIP_HOLD);

    // stage 1
    mag_t mag;
    logic v1;

    // stage 2 state
    mag_t          env;
    mag_t          peak;
    logic [DW-1:0] decay_cnt;
    logic [HW-1:0] hold_cnt;
    logic [CW-1:0] clip_cnt;

    mag_t          env_nxt;
    mag_t          peak_nxt;
    mag_t          step;
    logic [DW-1:0] decay_cnt_nxt;
    logic [HW-1:0] hold_cnt_nxt;
    logic [CW-1:0] clip_cnt_nxt;

    logic [3:0]      bin_env;
    logic [3:0]      bin_peak;
    logic [LEDS-1:0] led_nxt;

    always_ff @(posedge clk or negedge arstn) begin
        if (!arstn) begin
            mag <= '0;
            v1  <= 1'b0;
        end else begin
            v1 <= pcm.tvalid_pcm;
            if (pcm.tvalid_pcm) mag <= pcm_abs(pcm.tdata_pcm);
        end
    end

    always_comb begin
        env_nxt       = env;
        peak_nxt      = peak;
        decay_cnt_nxt = decay_cnt;
        hold_cnt_nxt  = hold_cnt;
        clip_cnt_nxt  = clip_cnt;
        // Small envelopes would otherwise shift to a zero step and stall.
        step = env >> DECAY_SHIFT;
        if (step == '0 && env != '0) step = mag_t'(1);

        if (v1) begin
            if (mag > env) begin
                env_nxt       = mag;
                decay_cnt_nxt = '0;
            end else if (decay_cnt == DW'(DECAY_EVERY - 1)) begin
                env_nxt       = env - step;
                decay_cnt_nxt = '0;
            end else begin
                decay_cnt_nxt = decay_cnt + 1'b1;
            end

            // Fall-back uses the envelope as it stood before this sample.
            if (mag >= peak) begin
                peak_nxt     = mag;
                hold_cnt_nxt = '0;
            end else if (hold_cnt == HW'(HOLD_SAMPLES - 1)) begin
                peak_nxt = env;
            end else begin
                hold_cnt_nxt = hold_cnt + 1'b1;
            end

            if (32'(mag) >= CLIP_THRESH)
                clip_cnt_nxt = CW'(CLIP_HOLD - 1);
            else if (clip_cnt != '0)
                clip_cnt_nxt = clip_cnt - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge arstn) begin
        if (!arstn) begin
            env       <= '0;
            peak      <= '0;
            decay_cnt <= '0;
            hold_cnt  <= '0;
            clip_cnt  <= '0;
        end else begin
            env       <= env_nxt;
            peak      <= peak_nxt;
            decay_cnt <= decay_cnt_nxt;
            hold_cnt  <= hold_cnt_nxt;
            clip_cnt  <= clip_cnt_nxt;
        end
    end

    assign level = env;

    pcm_log2_bin u_bin_env  (.x(env),  .bin(bin_env));
    pcm_log2_bin u_bin_peak (.x(peak), .bin(bin_peak));

    always_comb begin
        led_nxt = '0;
        for (int i = 0; i < LEDS; i++) begin
            led_nxt[i] = (5'(i) < {1'b0, bin_env}) ||
                         (bin_peak != '0 && {1'b0, bin_peak} == 5'(i + 1));
        end
    end

    // State only moves on samples, so refreshing every cycle still holds
    // the outputs steady between samples.
    always_ff @(posedge clk or negedge arstn) begin
        if (!arstn) begin
            led      <= '0;
            clip_led <= 1'b0;
        end else begin
            led      <= led_nxt;
            clip_led <= (clip_cnt != '0);
        end
    end

endmodule

// File: tb/tb_pcm_level_meter.sv
module tb_pcm_level_meter;

    logic        clk = 1'b0;
    logic        arstn = 1'b0;
    logic [14:0] level;
    logic [15:0] led;
    logic        clip_led;

    pcm_level_meter_if pcm ();

    pcm_level_meter u_dut (
        .clk      (clk),
        .arstn    (arstn),
        .pcm      (pcm.slave),
        .level    (level),
        .led      (led),
        .clip_led (clip_led)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    typedef struct {
        int          stamp;
        logic [14:0] level;
        logic [15:0] led;
        logic        clip;
    } exp_t;

    exp_t exp_lvl[$];
    exp_t exp_out[$];

    // reference model state
    int m_env, m_peak, m_dc, m_hold, m_clip;

    function automatic int bin_of(input int x);
        int b = 0;
        for (int i = 0; i < 16; i++) if (((x >> i) & 1) != 0) b = i + 1;
        return b;
    endfunction

    function automatic logic [15:0] exp_led(input int env, input int pk);
        logic [15:0] r = '0;
        int be = bin_of(env);
        int bp = bin_of(pk);
        for (int i = 0; i < 16; i++) if (i < be) r[i] = 1'b1;
        if (bp != 0) r[bp-1] = 1'b1;
        return r;
    endfunction

    task automatic model_reset;
        m_env = 0; m_peak = 0; m_dc = 0; m_hold = 0; m_clip = 0;
    endtask

    task automatic model(input int s);
        int mag, old_env, stp;
        mag = (s < 0) ? -s : s;
        if (mag > 32767) mag = 32767;
        old_env = m_env;
        if (mag > m_env) begin
            m_env = mag; m_dc = 0;
        end else if (m_dc == 63) begin
            stp = m_env / 8;
            if (stp == 0 && m_env != 0) stp = 1;
            m_env = m_env - stp; m_dc = 0;
        end else m_dc++;
        if (mag >= m_peak) begin
            m_peak = mag; m_hold = 0;
        end else if (m_hold == 4095) m_peak = old_env;
        else m_hold++;
        if (mag >= 32000) m_clip = 8191;
        else if (m_clip != 0) m_clip--;
    endtask

    // Drive one sample for one cycle; caller returns #1 after a posedge.
    task automatic drive(input int v);
        exp_t e;
        pcm.tdata_pcm  = 16'(v);
        pcm.tvalid_pcm = 1'b1;
        model(v);
        e.stamp = cyc;
        e.level = 15'(m_env);
        e.led   = exp_led(m_env, m_peak);
        e.clip  = (m_clip != 0);
        exp_lvl.push_back(e);
        exp_out.push_back(e);
        @(posedge clk); #1;
        pcm.tvalid_pcm = 1'b0;
    endtask

    task automatic idle(input int n);
        pcm.tvalid_pcm = 1'b0;
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic send(input int v, input int gap);
        drive(v);
        if (gap > 1) idle(gap - 1);
    endtask

    task automatic drain;
        int n = 0;
        while (exp_out.size() != 0 && n < 20) begin
            @(posedge clk); #1; n++;
        end
        chk("drain", exp_out.size(), 0);
    endtask

    task automatic pulse_reset;
        @(posedge clk); #1;
        arstn = 1'b0;
        exp_lvl.delete();
        exp_out.delete();
        model_reset();
        #1;
        chk("rst_level", level, 0);
        chk("rst_led", led, 0);
        chk("rst_clip", clip_led, 0);
        @(posedge clk); #1;
        arstn = 1'b1;
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (exp_lvl.size() != 0 && cyc == exp_lvl[0].stamp + 2) begin
            e = exp_lvl.pop_front();
            chk("level", level, e.level);
        end
        if (exp_out.size() != 0 && cyc == exp_out[0].stamp + 3) begin
            e = exp_out.pop_front();
            chk("led", led, e.led);
            chk("clip_led", clip_led, e.clip);
        end
    end

    initial begin
        pcm.tdata_pcm  = '0;
        pcm.tvalid_pcm = 1'b0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        chk("init_level", level, 0);
        chk("init_led", led, 0);
        chk("init_clip", clip_led, 0);
        arstn = 1'b1;
        idle(2);

        // reset while a sample is in flight
        drive(20000);
        pulse_reset();
        send(0, 4);
        drain();
        chk("post_rst_level", level, 0);
        chk("post_rst_led", led, 0);

        // single 0x4000 then slow decay
        send(16384, 4);
        drain();
        chk("l4000_level", level, 16384);
        chk("l4000_led", led, 16'h7FFF);
        for (int k = 0; k < 64; k++) send(0, 4);
        drain();
        chk("l4000_decay", level, 14336);

        // back-to-back strobes
        pulse_reset();
        drive(100);
        drive(200);
        drive(50);
        idle(1);
        drain();
        chk("b2b_led", led, 16'h00FF);
        chk("b2b_level", level, 200);

        // clip hold
        pulse_reset();
        send(-32768, 2);
        drain();
        chk("clip_level", level, 32767);
        chk("clip_on", clip_led, 1);
        for (int k = 1; k <= 8191; k++) begin
            send(0, 2);
            if (k == 8190) begin drain(); chk("clip_last_on", clip_led, 1); end
            if (k == 8191) begin drain(); chk("clip_off", clip_led, 0); end
        end

        // peak hold and fall-back
        pulse_reset();
        send(1024, 2);
        for (int k = 1; k <= 4096; k++) begin
            send(0, 2);
            if (k == 2048 || k == 4095) begin
                drain();
                chk("pk_dot", led[10], 1);
                chk("pk_above", led[15:11], 0);
            end
            if (k == 4096) begin
                drain();
                chk("pk_fall", led, exp_led(m_env, m_env));
                chk("pk_dot_gone", led[10], 0);
            end
        end

        // decay floor
        pulse_reset();
        send(5, 2);
        for (int k = 1; k <= 384; k++) begin
            send(0, 2);
            if (k == 319) begin drain(); chk("floor_319", level, 1); end
            if (k == 320) begin drain(); chk("floor_320", level, 0); end
        end
        drain();
        chk("floor_nowrap", level, 0);

        // random mix
        for (int k = 0; k < 200; k++) send($urandom_range(0, 65535) - 32768, 1 + (k % 3));
        drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
